// File: rtl/cook_timer_pkg.sv
// Shared definitions for the MM:SS cook timer: FSM encoding and BCD digit limits.
package cook_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SET  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX_DIGIT    = 4'd9;
    localparam logic [3:0] BCD_MAX_SEC_TENS = 4'd5;

    function automatic logic is_bcd(input logic [3:0] d);
        return d <= BCD_MAX_DIGIT;
    endfunction

endpackage

// File: rtl/cook_timer_bcd_down_digit.sv
// One BCD display digit: clear, keypad shift-in, and decrement-with-borrow.
module bcd_down_digit #(
    parameter logic [3:0] WRAP = 4'd9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr_i,
    input  logic       shift_i,
    input  logic [3:0] shift_val_i,
    input  logic       borrow_i,
    output logic [3:0] value_o,
    output logic       borrow_o
);

    logic [3:0] value_q, value_d;

    always_comb begin
        value_d = value_q;
        if (clr_i) begin
            value_d = 4'd0;
        end else if (shift_i) begin
            value_d = shift_val_i;
        end else if (borrow_i) begin
            value_d = (value_q == 4'd0) ? WRAP : value_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= 4'd0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value_o  = value_q;
    assign borrow_o = borrow_i && (value_q == 4'd0);

endmodule

// File: rtl/cook_timer.sv
// Four-digit BCD MM:SS countdown timer with keypad entry, pause/resume and
// a done flag that tells the magnetron controller to stop.
module cook_timer
    import cook_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000,
    parameter int PRE_W    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clearn,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    input  logic       mag_on,
    output logic       timer_done,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones
);

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_q, pre_d;

    logic        clr, shift, tick;
    logic        entry_ok, last_sec;
    logic        b_so, b_st, b_mo, underflow;
    logic [15:0] time_v;

    assign time_v   = {min_tens, min_ones, sec_tens, sec_ones};
    assign last_sec = (time_v == 16'h0001);
    assign entry_ok = !mag_on && digit_valid && is_bcd(digit);

    // Priority: clear > keypad entry > counting. The prescaler only advances
    // while the magnetron is on and there is time left, and holds across a pause.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        clr     = 1'b0;
        shift   = 1'b0;
        tick    = 1'b0;
        if (!clearn) begin
            clr     = 1'b1;
            pre_d   = '0;
            state_d = ST_IDLE;
        end else if (entry_ok) begin
            shift   = 1'b1;
            pre_d   = '0;
            state_d = ({min_ones, sec_tens, sec_ones, digit} == 16'h0000) ? ST_IDLE : ST_SET;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mag_on) state_d = ST_DONE;
                end
                ST_SET, ST_RUN: begin
                    if (!mag_on) begin
                        state_d = ST_SET;
                    end else begin
                        state_d = ST_RUN;
                        if (pre_q == PRE_LAST) begin
                            pre_d = '0;
                            tick  = 1'b1;
                            // underflow cannot occur with nonzero time; treated as done anyway
                            if (last_sec || underflow) state_d = ST_DONE;
                        end else begin
                            pre_d = pre_q + PRE_W'(1);
                        end
                    end
                end
                ST_DONE: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    assign timer_done = (state_q == ST_DONE);

    bcd_down_digit #(.WRAP(BCD_MAX_DIGIT)) u_sec_ones (
        .clk(clk), .reset(reset), .clr_i(clr), .shift_i(shift),
        .shift_val_i(digit), .borrow_i(tick), .value_o(sec_ones), .borrow_o(b_so)
    );

    bcd_down_digit #(.WRAP(BCD_MAX_SEC_TENS)) u_sec_tens (
        .clk(clk), .reset(reset), .clr_i(clr), .shift_i(shift),
        .shift_val_i(sec_ones), .borrow_i(b_so), .value_o(sec_tens), .borrow_o(b_st)
    );

    bcd_down_digit #(.WRAP(BCD_MAX_DIGIT)) u_min_ones (
        .clk(clk), .reset(reset), .clr_i(clr), .shift_i(shift),
        .shift_val_i(sec_tens), .borrow_i(b_st), .value_o(min_ones), .borrow_o(b_mo)
    );

    bcd_down_digit #(.WRAP(BCD_MAX_DIGIT)) u_min_tens (
        .clk(clk), .reset(reset), .clr_i(clr), .shift_i(shift),
        .shift_val_i(min_ones), .borrow_i(b_mo), .value_o(min_tens), .borrow_o(underflow)
    );

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with a 4-cycle tick.
module tb_cook_timer;
    import cook_timer_pkg::*;

    logic       clk = 1'b0;
    logic       reset, clearn, digit_valid, mag_on;
    logic [3:0] digit;
    logic       timer_done;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic [15:0] disp;

    int checks = 0;
    int errors = 0;

    cook_timer #(.TICK_DIV(4), .PRE_W(2)) dut (
        .clk(clk), .reset(reset), .clearn(clearn), .digit_valid(digit_valid),
        .digit(digit), .mag_on(mag_on), .timer_done(timer_done),
        .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones)
    );

    always #5 clk = ~clk;

    assign disp = {min_tens, min_ones, sec_tens, sec_ones};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_valid = 1'b1;
        digit       = d;
        step(1);
        digit_valid = 1'b0;
        digit       = 4'd0;
    endtask

    task automatic clear();
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
    endtask

    initial begin
        reset = 1'b1; clearn = 1'b1; digit_valid = 1'b0; digit = 4'd0; mag_on = 1'b0;
        step(2);
        check("reset_disp", disp, 16'h0000);
        check("reset_done", timer_done, 1'b0);
        check("reset_state", dut.state_q, ST_IDLE);
        reset = 1'b0;

        key(4'd1); key(4'd3); key(4'd0);
        check("entry_0130", disp, 16'h0130);
        check("entry_state", dut.state_q, ST_SET);

        // full countdown from 01:30
        mag_on = 1'b1;
        step(4);
        check("first_tick", disp, 16'h0129);
        check("run_state", dut.state_q, ST_RUN);
        step(355);
        check("pre_final_disp", disp, 16'h0001);
        check("pre_final_done", timer_done, 1'b0);
        step(1);
        check("final_disp", disp, 16'h0000);
        check("final_done", timer_done, 1'b1);
        step(3);
        check("done_hold", timer_done, 1'b1);
        check("done_hold_disp", disp, 16'h0000);

        // mag_on falling keeps DONE; a key leaves it
        mag_on = 1'b0;
        step(1);
        check("done_magoff", timer_done, 1'b1);
        key(4'd5);
        check("done_key_done", timer_done, 1'b0);
        check("done_key_disp", disp, 16'h0005);

        // pause/resume keeps the prescaler phase
        clear();
        key(4'd3);
        mag_on = 1'b1;
        step(6);
        check("pause_before", disp, 16'h0002);
        mag_on = 1'b0;
        step(1);
        check("pause_state", dut.state_q, ST_SET);
        step(3);
        check("pause_hold", disp, 16'h0002);
        mag_on = 1'b1;
        step(1);
        check("resume_1clk", disp, 16'h0002);
        step(1);
        check("resume_2clk", disp, 16'h0001);
        step(3);
        check("last_no_done", timer_done, 1'b0);
        step(1);
        check("last_done", timer_done, 1'b1);
        check("last_disp", disp, 16'h0000);

        // borrow cases
        mag_on = 1'b0;
        clear();
        key(4'd9); key(4'd0);
        mag_on = 1'b1;
        step(4);
        check("borrow_0090", disp, 16'h0089);
        mag_on = 1'b0;
        step(1);
        clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        check("entry_1000", disp, 16'h1000);
        mag_on = 1'b1;
        step(4);
        check("borrow_1000", disp, 16'h0959);
        mag_on = 1'b0;
        step(1);
        clear();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        check("entry_9999", disp, 16'h9999);
        mag_on = 1'b1;
        step(4);
        check("count_9999", disp, 16'h9998);

        // ignored entries
        digit_valid = 1'b1; digit = 4'd7;
        step(1);
        digit_valid = 1'b0;
        check("key_in_run", disp, 16'h9998);
        mag_on = 1'b0;
        step(1);
        key(4'd12);
        check("key_non_bcd", disp, 16'h9998);
        check("key_non_bcd_st", dut.state_q, ST_SET);

        // clear while running, then zero start
        mag_on = 1'b1;
        step(1);
        clearn = 1'b0;
        step(1);
        clearn = 1'b1;
        check("clr_run_disp", disp, 16'h0000);
        check("clr_run_state", dut.state_q, ST_IDLE);
        check("clr_run_done", timer_done, 1'b0);
        step(1);
        check("zero_start", timer_done, 1'b1);

        // clear beats a same-cycle key
        mag_on = 1'b0;
        clearn = 1'b0; digit_valid = 1'b1; digit = 4'd4;
        step(1);
        clearn = 1'b1; digit_valid = 1'b0;
        check("clr_wins_disp", disp, 16'h0000);
        check("clr_wins_done", timer_done, 1'b0);
        key(4'd0);
        check("zero_key_state", dut.state_q, ST_IDLE);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
